// File: rtl/cdc_skew_monitor.sv
// Pairs toggles on a clk1-domain signal with toggles on a resynchronised clk2 signal,
// measures their skew in clk1 cycles and flags pairs that are too far apart.
module cdc_skew_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_SKEW    = 2,
    parameter int TIMEOUT     = 16,
    parameter int VCNT_W      = 8,
    localparam int SKW_W      = $clog2(TIMEOUT + 1)
) (
    input  logic              clk1,
    input  logic              reset_n,
    input  logic              a_in,
    input  logic              b_async,
    input  logic              clear_cnt,
    output logic              meas_valid,
    output logic [SKW_W-1:0]  skew_out,
    output logic              b_led,
    output logic              viol,
    output logic              timeout,
    output logic              orphan,
    output logic [VCNT_W-1:0] viol_cnt
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT_B = 2'd1;
    localparam logic [1:0] WAIT_A = 2'd2;

    function automatic logic [VCNT_W-1:0] sat_inc(input logic [VCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic skew_over(input logic [SKW_W-1:0] s);
        return int'(s) > MAX_SKEW;
    endfunction

    logic [SYNC_STAGES-1:0] b_sync_p0;
    logic [SYNC_STAGES-1:0] a_pipe_p0;
    logic                   a_s_p1;
    logic                   b_s_p1;
    logic                   a_s;
    logic                   b_s;
    logic                   edge_a;
    logic                   edge_b;

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [SKW_W-1:0]       cnt;
    logic [SKW_W-1:0]       cnt_nxt;
    logic                   open_edge;
    logic                   close_edge;
    logic                   rep;
    logic [SKW_W-1:0]       rep_skew;
    logic                   rep_bled;
    logic                   rep_orph;
    logic                   rep_to;
    logic                   rep_viol;

    // Stage p0: b is synchronised, a is delayed by the same depth so edges line up
    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            b_sync_p0 <= '0;
            a_pipe_p0 <= '0;
        end else begin
            b_sync_p0 <= {b_sync_p0[SYNC_STAGES-2:0], b_async};
            a_pipe_p0 <= {a_pipe_p0[SYNC_STAGES-2:0], a_in};
        end
    end

    assign a_s = a_pipe_p0[SYNC_STAGES-1];
    assign b_s = b_sync_p0[SYNC_STAGES-1];

    // Stage p1: previous levels for any-edge detection
    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            a_s_p1 <= 1'b0;
            b_s_p1 <= 1'b0;
        end else begin
            a_s_p1 <= a_s;
            b_s_p1 <= b_s;
        end
    end

    assign edge_a = a_s ^ a_s_p1;
    assign edge_b = b_s ^ b_s_p1;

    // In WAIT_B the opening side is a and the closing side is b; WAIT_A mirrors it.
    assign open_edge  = (state == WAIT_A) ? edge_b : edge_a;
    assign close_edge = (state == WAIT_A) ? edge_a : edge_b;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rep       = 1'b0;
        rep_skew  = '0;
        rep_bled  = 1'b0;
        rep_orph  = 1'b0;
        rep_to    = 1'b0;
        case (state)
            IDLE: begin
                if (edge_a && edge_b) begin
                    rep = 1'b1;
                end else if (edge_a) begin
                    state_nxt = WAIT_B;
                    cnt_nxt   = '0;
                end else if (edge_b) begin
                    state_nxt = WAIT_A;
                    cnt_nxt   = '0;
                end
            end
            WAIT_B, WAIT_A: begin
                rep_bled = (state == WAIT_A);
                if (close_edge) begin
                    rep      = 1'b1;
                    rep_skew = cnt + 1'b1;
                    cnt_nxt  = '0;
                    if (!open_edge) begin
                        state_nxt = IDLE;
                    end
                end else if (open_edge) begin
                    rep      = 1'b1;
                    rep_skew = cnt + 1'b1;
                    rep_orph = 1'b1;
                    cnt_nxt  = '0;
                end else if (cnt == SKW_W'(TIMEOUT - 1)) begin
                    rep       = 1'b1;
                    rep_skew  = SKW_W'(TIMEOUT);
                    rep_to    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign rep_viol = rep & (rep_orph | rep_to | skew_over(rep_skew));

    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Stage p2: registered report and violation counter
    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            meas_valid <= 1'b0;
            viol       <= 1'b0;
            timeout    <= 1'b0;
            orphan     <= 1'b0;
            skew_out   <= '0;
            b_led      <= 1'b0;
            viol_cnt   <= '0;
        end else begin
            meas_valid <= rep;
            viol       <= rep_viol;
            timeout    <= rep_to;
            orphan     <= rep_orph;
            if (rep) begin
                skew_out <= rep_skew;
                b_led    <= rep_bled;
            end
            if (clear_cnt) begin
                viol_cnt <= '0;
            end else if (viol) begin
                viol_cnt <= sat_inc(viol_cnt);
            end
        end
    end

endmodule

// File: doc/cdc_skew_monitor.md
Name: cdc_skew_monitor

Overview:
- Consumes the two registered outputs of the dual-clock capture stage. `a_in` comes from the `clk1` domain; `b_async` comes from the `clk2` domain.
- Brings `b_async` into the `clk1` domain and pairs each toggle on one input with the next toggle on the other.
- Measures the skew between paired toggles in `clk1` cycles and flags any pair whose skew exceeds a limit.
- Sits directly downstream of the capture flops and drives a status/debug register bank.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for `b_async`; legal range is 2 or more.
- MAX_SKEW, 2, largest skew in `clk1` cycles that is not a violation.
- TIMEOUT, 16, largest wait for a partner edge before abandoning the measurement; must be 2 or more.
- VCNT_W, 8, width of the violation counter.
- SKW_W (localparam), $clog2(TIMEOUT+1), width of the skew counter and of `skew_out`.

Ports:
- clk1  in  1  sole clock; all logic is clocked on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a_in  in  1  signal already in the `clk1` domain.
- b_async  in  1  signal from the `clk2` domain, asynchronous to `clk1`.
- clear_cnt  in  1  synchronous clear of `viol_cnt`.
- meas_valid  out  1  one-cycle pulse marking a completed or abandoned measurement.
- skew_out  out  SKW_W  skew of the last measurement, in `clk1` cycles.
- b_led  out  1  1 when `b` toggled first in the last measurement.
- viol  out  1  one-cycle pulse when a skew exceeds MAX_SKEW, on timeout, or on an orphan edge.
- timeout  out  1  one-cycle pulse on timeout.
- orphan  out  1  one-cycle pulse on a repeated same-side edge.
- viol_cnt  out  VCNT_W  number of `viol` pulses, saturating.

Behaviour:
- Reset: every flop clears to 0, including the synchronizer, the matching pipe and the edge registers. FSM goes to IDLE; all outputs are 0.
- Input conditioning:
  - `b_async` passes through a SYNC_STAGES-deep flop chain to give `b_s`.
  - `a_in` passes through a SYNC_STAGES-deep plain pipe to give `a_s`, so both paths have equal latency.
  - `edge_a` = `a_s` XOR its previous value; `edge_b` = `b_s` XOR its previous value. Both rise and fall count as edges.
- FSM states: IDLE, WAIT_B, WAIT_A. The skew counter `cnt` is SKW_W bits wide.
- In IDLE:
  - `edge_a` and `edge_b` together: completed measurement with skew 0 and `b_led`=0; stay in IDLE.
  - `edge_a` only: go to WAIT_B with `cnt`=0.
  - `edge_b` only: go to WAIT_A with `cnt`=0.
- In WAIT_B (WAIT_A is the mirror image, with `b_led`=1):
  - `edge_b` (closing edge): completed measurement with skew = `cnt`+1.
    - If `edge_a` occurs in the same cycle, it opens a new measurement: go to WAIT_B with `cnt`=0.
    - Otherwise go to IDLE.
  - `edge_a` without `edge_b` (orphan): report a measurement with skew = `cnt`+1, pulse `orphan` and `viol`, restart WAIT_B with `cnt`=0.
  - No edge and `cnt`==TIMEOUT-1: report skew=TIMEOUT, pulse `timeout` and `viol`, go to IDLE.
  - No edge otherwise: `cnt`<=`cnt`+1.
- Reporting:
  - All outputs are registered; `meas_valid`, `viol`, `timeout` and `orphan` assert in the cycle after the deciding cycle.
  - `skew_out` and `b_led` update together with `meas_valid` and hold until the next report.
  - A completed measurement with skew > MAX_SKEW pulses `viol`. Skew == MAX_SKEW is not a violation.
- Violation counter:
  - `viol_cnt` increments on each `viol` pulse and saturates at all-ones.
  - `clear_cnt` forces it to 0 and wins over a simultaneous increment.
- Reset mid-measurement: the measurement is abandoned with no pulse, and the FSM is in IDLE once reset releases.
- Detection delay of `b_async` relative to `clk2` adds up to one `clk1` cycle of uncertainty. The measured skew carries ±1 cycle of CDC jitter, and this is accepted.

Test Plan:
- Reset with a 0→1 toggle on `a_in`, and `b_async` toggling 0→1 in the same `clk1` cycle and held -> one `meas_valid`, `skew_out`=0, `b_led`=0, no `viol`.
- `a_in` toggles, then `b_async` toggles so that `edge_b` lands 3 cycles after `edge_a`, with MAX_SKEW=2 -> `skew_out`=3, `b_led`=0, `viol` pulse, `viol_cnt`=1.
- `b_async` toggles first and `edge_a` follows 2 cycles later -> `skew_out`=2, `b_led`=1, no `viol`.
- `a_in` toggles once and `b_async` stays quiet -> `timeout`, `viol` and `meas_valid` pulse 17 cycles after `edge_a`, `skew_out`=16, FSM in IDLE.
- `a_in` toggles twice 4 cycles apart with no `b` edge -> `orphan` and `viol` pulse with `skew_out`=4. A later `edge_b` 1 cycle after the second `edge_a` gives `skew_out`=1.
- Force 300 violations with VCNT_W=8 -> `viol_cnt` holds at 255. Then `clear_cnt` coinciding with a `viol` pulse -> `viol_cnt`=0. Assert `reset_n` low while in WAIT_B -> all outputs 0 and no pulse after release.
